// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory write port of the program loader.
// master = host/link side, slave = loader side.
interface imem_loader_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_waddr, mem_wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Length-prefixed LE byte stream -> 32-bit instruction memory writes; holds CPU in reset while loading.
// Latency: mem_we one cycle after a word's 4th byte; one byte/cycle sustained.
// Backpressure: in_ready is a pure function of state; optional trailing XOR byte via IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         err,
    output logic [15:0]  word_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_CHK    = 3'd5;

    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    logic [2:0]  state;
    logic [15:0] len;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic        xfer;
    logic [15:0] len_rx;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xsum;
`endif

    assign bus.in_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                          (state == S_DATA)   || (state == S_CHK);
    assign xfer   = bus.in_valid && bus.in_ready;
    assign len_rx = {bus.in_data, len[7:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            len           <= '0;
            byte_idx      <= '0;
            word_buf      <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
            cpu_hold      <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            word_count    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xsum          <= '0;
`endif
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_LEN_LO;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum       <= '0;
`endif
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.in_data;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.in_data;
                        if (len_rx == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state    <= S_CHK;
`else
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
`endif
                        end else if ({1'b0, len_rx} > DEPTH_W) begin
                            // Oversized image: reject before any write lands
                            state    <= S_DONE;
                            err      <= 1'b1;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= S_DATA;
                            byte_idx <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xsum <= xsum ^ bus.in_data;
`endif
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= {bus.in_data, word_buf};
                            bus.mem_waddr <= BASE_ADDR + {14'd0, word_count, 2'b00};
                            word_count    <= word_count + 16'd1;
                            if (word_count + 16'd1 == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state    <= S_CHK;
`else
                                state    <= S_DONE;
                                done     <= 1'b1;
                                cpu_hold <= 1'b0;
`endif
                            end
                        end else begin
                            // Shift right so byte 0 ends up in bits 7:0
                            word_buf <= {bus.in_data, word_buf[23:8]};
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        if (bus.in_data != xsum) err <= 1'b1;
                        state    <= S_DONE;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
